mem_port_arbiter: RTL and testbench

//   Shares one single-port memory (memory.v-style: wen/a/d/q) between the CHIP

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of one single-port memory.
// Define ARB_ROUND_ROBIN_EN for alternating arbitration; default is D-over-I priority with a starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  logic [1:0]        r_state;
  logic              r_owner_d;
  logic              r_is_wr;
  logic [LAT_W-1:0]  r_wait_cnt;
  logic              r_i_ack;
  logic              r_d_ack;
  logic              r_mem_wen;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_any_req;
  logic              w_grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;  // 1 = D port was granted last

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_grant_d = d_req;
    if (d_req && i_req) w_grant_d = !r_last_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_last_grant <= 1'b0;
    else if (r_state == S_IDLE && w_any_req) r_last_grant <= w_grant_d;
  end
`else
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  // Length of the current run of D grants taken while I was also waiting.
  logic [STV_W-1:0] r_starve_cnt;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_grant_d = d_req;
    if (d_req && i_req) w_grant_d = (r_starve_cnt < STV_W'(STARVE_LIM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE && w_any_req) begin
      if (w_grant_d && i_req) r_starve_cnt <= r_starve_cnt + STV_W'(1);
      else                    r_starve_cnt <= '0;
    end
  end
`endif

  assign w_any_req = i_req | d_req;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner_d   <= 1'b0;
      r_is_wr     <= 1'b0;
      r_wait_cnt  <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_mem_wen <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_ISSUE;
            r_owner_d  <= w_grant_d;
            r_is_wr    <= w_grant_d & d_wen;
            r_mem_wen  <= w_grant_d & d_wen;
            r_mem_addr <= w_grant_d ? d_addr : i_addr;
            if (w_grant_d) r_mem_wdata <= d_wdata;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= LAT_W'(MEM_LAT);
          if (r_is_wr) begin
            r_state <= S_DONE;
            r_d_ack <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Last WAIT cycle: q now reflects the address presented MEM_LAT cycles ago.
          if (r_wait_cnt == LAT_W'(1)) begin
            r_state <= S_DONE;
            if (r_owner_d) begin
              r_d_rdata <= mem_rdata;
              r_d_ack   <= 1'b1;
            end else begin
              r_i_rdata <= mem_rdata;
              r_i_ack   <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - LAT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model (grant cycle -> issue/ack cycles, data from a reference memory).
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 1;
  localparam int STARVE_LIM = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req = 1'b0;
  logic              d_wen = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Physical memory seen by the DUT: synchronous write, MEM_LAT-cycle read pipeline.
  logic [DATA_W-1:0] phys_mem [0:63];
  logic [DATA_W-1:0] rd_pipe  [0:MEM_LAT-1];
  always @(posedge clk) begin
    if (mem_wen) phys_mem[mem_addr[7:2]] <= mem_wdata;
    rd_pipe[0] <= phys_mem[mem_addr[7:2]];
    for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Reference model state
  logic [DATA_W-1:0] ref_mem [0:63];
  int                cyc = 0;
  bit                m_act = 1'b0;
  int                m_issue, m_done;
  bit                m_own_d, m_wr;
  logic [DATA_W-1:0] m_rdata, m_wdata_pend, m_last_ird, m_last_drd;
  logic [ADDR_W-1:0] m_addr_pend, exp_mem_addr;
  int                streak = 0;
  bit                last_d = 1'b0;
  bit                ev_ia, ev_da;
  int                wen_cnt = 0;
  bit                order_q [$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom_range(63)) << 2;
    return a;
  endfunction

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    bit idle;
    bit issue_now;
    @(negedge clk);
    cyc++;
    idle      = !m_act || (cyc > m_done);
    issue_now = m_act && (cyc == m_issue);
    ev_ia     = m_act && (cyc == m_done) && !m_own_d;
    ev_da     = m_act && (cyc == m_done) && m_own_d;
    if (issue_now) exp_mem_addr = m_addr_pend;
    check("busy",     64'(busy),     64'(!idle));
    check("i_ack",    64'(i_ack),    64'(ev_ia));
    check("d_ack",    64'(d_ack),    64'(ev_da));
    check("mem_wen",  64'(mem_wen),  64'(issue_now && m_wr));
    check("mem_addr", 64'(mem_addr), 64'(exp_mem_addr));
    if (issue_now && m_wr) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata_pend));
    if (ev_ia) begin
      check("i_rdata", 64'(i_rdata), 64'(m_rdata));
      m_last_ird = m_rdata;
    end
    if (ev_da) begin
      if (m_wr) begin
        check("d_rdata_hold", 64'(d_rdata), 64'(m_last_drd));
      end else begin
        check("d_rdata", 64'(d_rdata), 64'(m_rdata));
        m_last_drd = m_rdata;
      end
    end
    if (mem_wen) wen_cnt++;
    if (i_ack) order_q.push_back(1'b0);
    if (d_ack) order_q.push_back(1'b1);
  endtask

  // Apply the arbitration rules to the inputs presented in the current cycle.
  task automatic sample();
    bit pick_d;
    if ((!m_act || cyc > m_done) && (i_req || d_req)) begin
      pick_d = d_req;
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = !last_d;
`else
        pick_d = (streak < STARVE_LIM);
`endif
      end
      streak  = (pick_d && i_req) ? streak + 1 : 0;
      last_d  = pick_d;
      m_act   = 1'b1;
      m_own_d = pick_d;
      m_wr    = pick_d && d_wen;
      m_issue = cyc + 1;
      m_done  = cyc + 2 + (m_wr ? 0 : MEM_LAT);
      m_addr_pend  = pick_d ? d_addr : i_addr;
      m_wdata_pend = d_wdata;
      if (m_wr) ref_mem[m_addr_pend[7:2]] = d_wdata;
      else      m_rdata = ref_mem[m_addr_pend[7:2]];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    #1;
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_mem_wen",   64'(mem_wen),   64'(0));
    check("rst_i_ack",     64'(i_ack),     64'(0));
    check("rst_d_ack",     64'(d_ack),     64'(0));
    check("rst_mem_addr",  64'(mem_addr),  64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_i_rdata",   64'(i_rdata),   64'(0));
    check("rst_d_rdata",   64'(d_rdata),   64'(0));
    m_act = 1'b0;
    streak = 0;
    last_d = 1'b0;
    exp_mem_addr = '0;
    m_last_ird = '0;
    m_last_drd = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input bit port_d, input bit hold, output int ack_cyc);
    bit seen;
    seen = 1'b0;
    ack_cyc = -1;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick();
      if (port_d ? d_ack : i_ack) begin
        seen = 1'b1;
        ack_cyc = cyc;
        if (!hold) begin
          if (port_d) d_req = 1'b0;
          else        i_req = 1'b0;
        end
      end
      sample();
    end
    if (!seen) check(port_d ? "d_ack_timeout" : "i_ack_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n, a1, a2, w0;
    logic [DATA_W-1:0] v;
    for (int k = 0; k < 64; k++) begin
      v = $urandom;
      ref_mem[k]  = v;
      phys_mem[k] = v;
    end
    ref_mem[1] = 32'h0000_0013;
    phys_mem[1] = 32'h0000_0013;
    #3;
    do_reset();

    // Instruction fetch latency and data
    tick();
    i_req = 1'b1; i_addr = 32'h04;
    sample(); n = cyc;
    wait_ack(1'b0, 1'b0, a1);
    check("t1_latency", 64'(a1 - n), 64'(2 + MEM_LAT));
    check("t1_rdata",   64'(i_rdata), 64'(32'h0000_0013));

    // Data write then read-back
    tick();
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    sample(); n = cyc; w0 = wen_cnt;
    wait_ack(1'b1, 1'b0, a1);
    check("t2_wr_latency", 64'(a1 - n), 64'(2));
    check("t2_wen_cycles", 64'(wen_cnt - w0), 64'(1));
    tick();
    d_req = 1'b1; d_wen = 1'b0;
    sample();
    wait_ack(1'b1, 1'b0, a1);
    check("t2_readback", 64'(d_rdata), 64'(32'hDEAD_BEEF));

    // Contention ordering
    tick();
    order_q.delete();
    i_req = 1'b1; d_req = 1'b1; d_wen = 1'b0; i_addr = 32'h00; d_addr = 32'h40;
    sample();
    for (int k = 0; k < 200 && order_q.size() < 10; k++) begin
      tick();
      if (ev_ia) i_addr = i_addr + 32'h4;
      if (ev_da) d_addr = d_addr + 32'h4;
      if (order_q.size() >= 10) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      sample();
    end
    check("t3_order_len", 64'(order_q.size()), 64'(10));
    for (int k = 0; k < 10 && k < order_q.size(); k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check($sformatf("t3_grant%0d", k), 64'(order_q[k]), 64'(k % 2 == 0));
`else
      check($sformatf("t3_grant%0d", k), 64'(order_q[k]), 64'(k % 5 != 4));
`endif
    end

    // Reset during the WAIT cycle of a read
    tick();
    i_req = 1'b1; i_addr = 32'h0C;
    sample();
    tick(); sample();
    tick();
    do_reset();
    tick();
    i_req = 1'b1; i_addr = 32'h0C;
    sample(); n = cyc;
    wait_ack(1'b0, 1'b0, a1);
    check("t4_latency", 64'(a1 - n), 64'(2 + MEM_LAT));

    // Request held across ack: back-to-back reads
    tick();
    i_req = 1'b1; i_addr = 32'h00;
    sample();
    wait_ack(1'b0, 1'b1, a1);
    i_addr = 32'h08;
    wait_ack(1'b0, 1'b0, a2);
    check("t5_spacing", 64'(a2 - a1), 64'(MEM_LAT + 3));
    check("t5_rdata",   64'(i_rdata), 64'(ref_mem[2]));

    // D request arriving while an I read is in WAIT
    tick();
    i_req = 1'b1; i_addr = 32'h14;
    sample();
    tick(); sample();
    tick();
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h18; d_wdata = 32'h1234_5678;
    sample();
    wait_ack(1'b0, 1'b0, a1);
    wait_ack(1'b1, 1'b0, a2);
    check("t6_d_after_i", 64'(a2 - a1), 64'(3));

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (ev_ia) begin
        i_req = 1'($urandom_range(1));
        i_addr = rnd_addr();
      end else if (!i_req) begin
        if ($urandom_range(3) == 0) begin
          i_req = 1'b1;
          i_addr = rnd_addr();
        end
      end else if ($urandom_range(4) == 0) begin
        i_addr = rnd_addr();
      end
      if (ev_da || (!d_req && $urandom_range(3) == 0)) begin
        d_req   = ev_da ? 1'($urandom_range(1)) : 1'b1;
        d_wen   = 1'($urandom_range(1));
        d_addr  = rnd_addr();
        d_wdata = $urandom;
      end else if (d_req && $urandom_range(4) == 0) begin
        d_wen   = 1'($urandom_range(1));
        d_addr  = rnd_addr();
        d_wdata = $urandom;
      end
      sample();
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (8) begin
      tick();
      sample();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
